vga_ram_writer: RTL

Write-side front end for the VGA frame RAM: accepts store and fill commands from the CPU over a valid/ready handshake, buffers them in a small FIFO, and drains them onto the RAM write port (port B) at up to one word per clock. It sits directly upstream of the VGA RAM consumed by the pixel generator, whose port A stays read-only. Fill commands write one data word to a run of consecutive addresses so the CPU can clear or paint regions without issuing per-word stores.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_ram_writer_if.sv | 34 +++
 rtl/vga_cmd_fifo.sv | 63 ++++++
 rtl/vga_ram_writer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA RAM width set and command record, used by both the writer and pixel-generator sides.
package vga_pkg;

  localparam int unsigned VGA_ADDR_W = 14;
  localparam int unsigned VGA_DATA_W = 16;

  typedef struct packed {
    logic                  fill;
    logic [VGA_ADDR_W-1:0] addr;
    logic [VGA_DATA_W-1:0] data;
    logic [VGA_ADDR_W-1:0] len;
  } vga_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FILL
  } wr_state_e;

endpackage

// File: rtl/vga_ram_writer_if.sv
// CPU-side command handshake for the VGA RAM writer.
interface vga_ram_writer_if
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W = VGA_ADDR_W,
  parameter int unsigned DATA_W = VGA_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_fill;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic [ADDR_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_fill,
    output cmd_addr,
    output cmd_data,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_fill,
    input  cmd_addr,
    input  cmd_data,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/vga_cmd_fifo.sv
// Count-based synchronous FIFO holding queued VGA write commands.
module vga_cmd_fifo
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter type         entry_t    = vga_cmd_t,
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/vga_ram_writer.sv
// Drains queued store/fill commands onto VGA RAM port B at up to one word per clock.
module vga_ram_writer
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W     = VGA_ADDR_W,
  parameter int unsigned DATA_W     = VGA_DATA_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  vga_ram_writer_if.slave     cmd,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;

  vga_cmd_t          push_entry, head;
  logic              push, pop, full, empty;
  logic [CNT_W-1:0]  count;

  assign push          = cmd.cmd_valid && cmd_ready_q;
  assign cmd.cmd_ready = cmd_ready_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign busy          = busy_q;

  always_comb begin
    push_entry.fill = cmd.cmd_fill;
    push_entry.addr = cmd.cmd_addr;
    push_entry.data = cmd.cmd_data;
    push_entry.len  = cmd.cmd_len;
  end

  vga_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .entry_t    (vga_cmd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // rem_q counts words still to issue after the one currently on the bus;
  // the last word of any command is always presented from ST_WRITE, so
  // chaining to the next head needs only one place.
  always_comb begin
    state_d    = state_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rem_d      = rem_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WRITE: begin
        state_d = ST_IDLE;
        if (!empty) begin
          pop = 1'b1;
          if (!head.fill) begin
            ram_we_d   = 1'b1;
            ram_addr_d = head.addr;
            ram_din_d  = head.data;
            state_d    = ST_WRITE;
          end else if (head.len != '0) begin
            ram_we_d   = 1'b1;
            ram_addr_d = head.addr;
            ram_din_d  = head.data;
            rem_d      = head.len - ADDR_W'(1);
            state_d    = (head.len == ADDR_W'(1)) ? ST_WRITE : ST_FILL;
          end
        end
      end
      ST_FILL: begin
        ram_we_d   = 1'b1;
        ram_addr_d = ram_addr_q + ADDR_W'(1);
        rem_d      = rem_q - ADDR_W'(1);
        if (rem_q == ADDR_W'(1)) state_d = ST_WRITE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop never raises ready in the same cycle; a push into the last free slot drops it.
  always_comb begin
    cmd_ready_d = !full && !(push && !pop && (count == CNT_W'(FIFO_DEPTH - 1)));
    busy_d      = !empty || (state_q != ST_IDLE) || ram_we_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

endmodule
